pattern_player: RTL and testbench

Plays the memory-game cue sequence on the eight LEDs. It is the output-side counterpart of the button-input path in `GameManager`. On `start` it generates a pseudo-random sequence of LED indices from a seed and shows them one at a time, paced by the 0.2 s game tick, with an on-time set by the difficulty level. Each shown index is also published on a step strobe, so the input checker can record the expected button order.

---
 rtl/pattern_player_if.sv | 32 +++
 rtl/pattern_player.sv | 188 ++++++++++++++++++
 tb/tb_pattern_player.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_player_if.sv
// pattern_player_if
//   Groups the playback control inputs and the LED/step outputs of
//   pattern_player into one bundle.
//   master : drives tick, start, abort, seq_len, level, seed;
//            receives led, step_idx, step_valid, busy, done.
//   slave  : the player side (directions mirrored).
//   LEN_W  : width of seq_len; must match the player's LEN_W.
interface pattern_player_if #(
    parameter int LEN_W = 5
);
    logic             tick;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] seq_len;
    logic [1:0]       level;
    logic [15:0]      seed;
    logic [7:0]       led;
    logic [2:0]       step_idx;
    logic             step_valid;
    logic             busy;
    logic             done;

    modport master (
        output tick, start, abort, seq_len, level, seed,
        input  led, step_idx, step_valid, busy, done
    );

    modport slave (
        input  tick, start, abort, seq_len, level, seed,
        output led, step_idx, step_valid, busy, done
    );
endinterface

// File: rtl/pattern_player.sv
// pattern_player
//   Plays the memory-game cue sequence on eight LEDs. On an accepted start
//   it seeds a 16-bit Galois LFSR and shows seq_len pseudo-random LED
//   indices, one per step, paced by the game tick. Each step is lit for
//   (3 - level) ticks followed by a one-tick gap; every shown index is
//   published with a one-cycle step_valid strobe.
//
//   Ports:
//     clk_1  : system clock (rising edge)
//     rst_n  : asynchronous active-low reset
//     bus    : pattern_player_if.slave
//              in : tick, start, abort, seq_len[LEN_W], level[2], seed[16]
//              out: led[8], step_idx[3], step_valid, busy, done
//
//   Parameters: MAX_LEN (max steps), LEN_W (seq_len width, 2^LEN_W > MAX_LEN)
//
//   Optional feature macro: PATTERN_PLAYER_NO_REPEAT_EN
//     defined   : an index equal to the previous step's index is bumped to
//                 (idx+1) mod 8; the LFSR is untouched, first step never bumped
//     undefined : the raw LFSR index is always used
module pattern_player #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic            clk_1,
    input  logic            rst_n,
    pattern_player_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_ON,
        S_GAP
    } state_t;

    localparam logic [15:0]      SEED_SUB  = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]       on_ticks_q, on_ticks_d;
    logic [1:0]       on_cnt_q, on_cnt_d;
    logic [7:0]       led_q, led_d;
    logic [2:0]       step_idx_q, step_idx_d;
    logic             step_valid_q, step_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [15:0]      lfsr_adv;
    logic [2:0]       idx_new;
    logic             take_step;

    // Next LFSR state and the index it selects for a step taken this cycle.
    always_comb begin
        lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        idx_new  = lfsr_adv[15:13];
`ifdef PATTERN_PLAYER_NO_REPEAT_EN
        // step_cnt_q is 0 only for the first step of a playback
        if ((step_cnt_q != '0) && (idx_new == step_idx_q)) begin
            idx_new = idx_new + 3'd1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        len_d        = len_q;
        step_cnt_d   = step_cnt_q;
        on_ticks_d   = on_ticks_q;
        on_cnt_d     = on_cnt_q;
        led_d        = led_q;
        step_idx_d   = step_idx_q;
        step_valid_d = 1'b0;
        done_d       = 1'b0;
        take_step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // a tick coinciding with start is deliberately not consumed
                if (bus.start) begin
                    lfsr_d = (bus.seed == '0) ? SEED_SUB : bus.seed;
                    if (bus.seq_len == '0) begin
                        len_d = LEN_W'(1);
                    end else if (bus.seq_len > LEN_MAX) begin
                        len_d = LEN_MAX;
                    end else begin
                        len_d = bus.seq_len;
                    end
                    on_ticks_d = (bus.level == 2'd3) ? 2'd1 : (2'd3 - bus.level);
                    step_cnt_d = '0;
                    state_d    = S_LEAD;
                end
            end
            S_LEAD: begin
                if (bus.tick) begin
                    take_step = 1'b1;
                end
            end
            S_ON: begin
                if (bus.tick) begin
                    if (on_cnt_q <= 2'd1) begin
                        led_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        on_cnt_d = on_cnt_q - 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (bus.tick) begin
                    if (step_cnt_q < len_q) begin
                        take_step = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_step) begin
            lfsr_d       = lfsr_adv;
            step_idx_d   = idx_new;
            led_d        = 8'd1 << idx_new;
            step_valid_d = 1'b1;
            on_cnt_d     = on_ticks_q;
            step_cnt_d   = step_cnt_q + LEN_W'(1);
            state_d      = S_ON;
        end

        // abort overrides everything decided above, including an IDLE start
        if (bus.abort) begin
            state_d      = S_IDLE;
            lfsr_d       = lfsr_q;
            len_d        = len_q;
            step_cnt_d   = step_cnt_q;
            on_ticks_d   = on_ticks_q;
            on_cnt_d     = on_cnt_q;
            led_d        = '0;
            step_idx_d   = step_idx_q;
            step_valid_d = 1'b0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            len_q        <= '0;
            step_cnt_q   <= '0;
            on_ticks_q   <= '0;
            on_cnt_q     <= '0;
            led_q        <= '0;
            step_idx_q   <= '0;
            step_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            len_q        <= len_d;
            step_cnt_q   <= step_cnt_d;
            on_ticks_q   <= on_ticks_d;
            on_cnt_q     <= on_cnt_d;
            led_q        <= led_d;
            step_idx_q   <= step_idx_d;
            step_valid_q <= step_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.step_valid = step_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player
//   Self-checking bench for pattern_player. Expected step indices come from
//   a sequence model computed with plain integer arithmetic; expected timing
//   comes from the tick-count formulas (step k at tick 1+k*(on+1), done at
//   tick 1+N*(on+1)). Honours PATTERN_PLAYER_NO_REPEAT_EN when defined.
module tb_pattern_player;

    logic clk_1 = 1'b0;
    logic rst_n;

    always #5 clk_1 = ~clk_1;

    pattern_player_if #(.LEN_W(5)) bus ();

    pattern_player #(
        .MAX_LEN(16),
        .LEN_W  (5)
    ) dut (
        .clk_1(clk_1),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] seed;
        logic [4:0]  len;
        logic [1:0]  level;
        int          gap;
        bit          start_tick;
        bit          mid_start;
        int          exp_first;
        int          exp_n;
        int          exp_ticks;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    int exp_idx_q[$];
    int obs_idx_q[$];
    int obs_n;
    int obs_first;
    int obs_ticks;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tb_cycle();
        @(posedge clk_1);
        #1;
    endtask

    // Expected index sequence for a playback.
    function automatic void model_seq(input logic [15:0] sd, input logic [4:0] ln);
        int n, s, idx, prev;
        n = (ln == 0) ? 1 : ((int'(ln) > 16) ? 16 : int'(ln));
        s = (sd == 16'h0) ? 'hACE1 : int'(sd);
        prev = -1;
        exp_idx_q.delete();
        for (int i = 0; i < n; i++) begin
            s   = ((s % 2) == 1) ? ((s / 2) ^ 'hB400) : (s / 2);
            idx = (s / 8192) % 8;
`ifdef PATTERN_PLAYER_NO_REPEAT_EN
            if (i > 0 && idx == prev) idx = (idx + 1) % 8;
`endif
            exp_idx_q.push_back(idx);
            prev = idx;
        end
    endfunction

    task automatic run_play(input logic [15:0] sd, input logic [4:0] ln, input logic [1:0] lv,
                            input int gap, input bit start_tick, input bit mid_start);
        int exp_n, on_t, total, budget, tcnt, cyc, done_cnt, step_tick, k;
        logic [7:0] led_prev;
        bit t;
        model_seq(sd, ln);
        exp_n  = exp_idx_q.size();
        on_t   = (lv == 2'd3) ? 1 : 3 - int'(lv);
        total  = 1 + exp_n * (on_t + 1);
        budget = (total + 4) * gap + 20;
        obs_idx_q.delete();
        obs_first = -1;
        obs_ticks = -1;
        tcnt = 0; cyc = 0; done_cnt = 0; step_tick = 0;
        led_prev = '0;

        bus.seed = sd; bus.seq_len = ln; bus.level = lv;
        bus.start = 1'b1; bus.tick = start_tick;
        tb_cycle();
        bus.start = 1'b0; bus.tick = 1'b0;
        bus.seed = 16'($urandom); bus.seq_len = 5'($urandom); bus.level = 2'($urandom);
        chk("busy_rise", int'(bus.busy), 1);
        chk("led_after_start", int'(bus.led), 0);

        while (done_cnt == 0 && cyc < budget) begin
            t = ((cyc % gap) == (gap - 1));
            bus.tick = t;
            if (t) tcnt++;
            bus.start = mid_start && (cyc == 3 * gap);
            tb_cycle();
            cyc++;
            if (bus.step_valid) begin
                k = obs_idx_q.size();
                obs_idx_q.push_back(int'(bus.step_idx));
                if (k < exp_n) begin
                    chk("step_idx", int'(bus.step_idx), exp_idx_q[k]);
                    chk("step_tick", tcnt, 1 + k * (on_t + 1));
                end else begin
                    chk("step_extra", k + 1, exp_n);
                end
                chk("led_onehot", int'(bus.led), 1 << int'(bus.step_idx));
                step_tick = tcnt;
            end
            if (led_prev != 8'h0 && bus.led == 8'h0) chk("on_ticks", tcnt - step_tick, on_t);
            if (bus.done) begin
                done_cnt++;
                obs_ticks = tcnt;
                chk("done_tick", tcnt, total);
                chk("busy_fall", int'(bus.busy), 0);
            end
            led_prev = bus.led;
        end
        bus.start = 1'b0; bus.tick = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        chk("step_count", obs_idx_q.size(), exp_n);
        tb_cycle();
        chk("done_width", int'(bus.done), 0);
        obs_n = obs_idx_q.size();
        if (obs_n > 0) obs_first = obs_idx_q[0];
    endtask

    task automatic abort_test();
        int seen, cyc, bad;
        bus.seed = 16'h0001; bus.seq_len = 5'd4; bus.level = 2'd0;
        bus.start = 1'b1; bus.tick = 1'b0;
        tb_cycle();
        bus.start = 1'b0;
        seen = 0; cyc = 0;
        while (cyc < 100) begin
            bus.tick = 1'b1;
            tb_cycle();
            cyc++;
            if (bus.step_valid) seen++;
            if (seen == 2 && bus.led == 8'h0) break;
        end
        chk("abort_reach_gap", seen, 2);
        // abort together with the GAP tick: the tick must not take step 3
        bus.abort = 1'b1; bus.tick = 1'b1;
        tb_cycle();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_led", int'(bus.led), 0);
        chk("abort_step_valid", int'(bus.step_valid), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_idx_hold", int'(bus.step_idx), 2);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            bus.tick = 1'b1;
            tb_cycle();
            if (bus.done || bus.step_valid || bus.busy || bus.led != 8'h0) bad++;
        end
        bus.tick = 1'b0;
        chk("abort_stays_idle", bad, 0);
        bus.start = 1'b1; bus.abort = 1'b1;
        tb_cycle();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_beats_start", int'(bus.busy), 0);
        tb_cycle();
        chk("abort_beats_start2", int'(bus.busy), 0);
    endtask

    task automatic reset_test();
        int cyc, bad;
        bus.seed = 16'h0001; bus.seq_len = 5'd4; bus.level = 2'd0;
        bus.start = 1'b1; bus.tick = 1'b0;
        tb_cycle();
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 20 && bus.led != 8'h20) begin
            bus.tick = 1'b1;
            tb_cycle();
            cyc++;
        end
        bus.tick = 1'b1;
        tb_cycle();
        bus.tick = 1'b0;
        chk("led_before_reset", int'(bus.led), 'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_led", int'(bus.led), 0);
        chk("rst_step_idx", int'(bus.step_idx), 0);
        chk("rst_step_valid", int'(bus.step_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        tb_cycle();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.tick = 1'b1;
            tb_cycle();
            if (bus.busy || bus.step_valid || bus.done || bus.led != 8'h0) bad++;
        end
        bus.tick = 1'b0;
        chk("idle_after_reset", bad, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0001, 5'd4,  2'd0, 1, 1'b0, 1'b0, 5, 4,  17};
        vecs[1] = '{16'h0001, 5'd0,  2'd0, 2, 1'b0, 1'b0, 5, 1,  5};
        vecs[2] = '{16'h0001, 5'd31, 2'd1, 1, 1'b0, 1'b0, 5, 16, 49};
        vecs[3] = '{16'h0000, 5'd3,  2'd2, 1, 1'b0, 1'b0, 7, 3,  7};
        vecs[4] = '{16'h1234, 5'd12, 2'd3, 1, 1'b0, 1'b0, 0, 12, 25};
        vecs[5] = '{16'h00FF, 5'd12, 2'd2, 3, 1'b0, 1'b0, 5, 12, 25};
        vecs[6] = '{16'h0001, 5'd4,  2'd0, 2, 1'b1, 1'b0, 5, 4,  17};
        vecs[7] = '{16'h0001, 5'd2,  2'd1, 1, 1'b0, 1'b1, 5, 2,  7};

        rst_n = 1'b0;
        bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.seq_len = '0; bus.level = '0; bus.seed = '0;
        repeat (2) @(posedge clk_1);
        #1;
        chk("reset_led", int'(bus.led), 0);
        chk("reset_step_idx", int'(bus.step_idx), 0);
        chk("reset_step_valid", int'(bus.step_valid), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        rst_n = 1'b1;
        tb_cycle();

        for (int i = 0; i < 8; i++) begin
            run_play(vecs[i].seed, vecs[i].len, vecs[i].level, vecs[i].gap,
                     vecs[i].start_tick, vecs[i].mid_start);
            chk("vec_first_idx", obs_first, vecs[i].exp_first);
            chk("vec_steps", obs_n, vecs[i].exp_n);
            chk("vec_total_ticks", obs_ticks, vecs[i].exp_ticks);
        end

        // seed 1 yields raw indices 5,2,1,0,0: the fifth step repeats
        run_play(16'h0001, 5'd5, 2'd2, 1, 1'b0, 1'b0);
        if (obs_idx_q.size() >= 5) begin
`ifdef PATTERN_PLAYER_NO_REPEAT_EN
            chk("repeat_step5", obs_idx_q[4], 1);
`else
            chk("repeat_step5", obs_idx_q[4], 0);
`endif
        end else begin
            chk("repeat_steps", obs_idx_q.size(), 5);
        end

        abort_test();
        run_play(16'h0001, 5'd1, 2'd2, 1, 1'b0, 1'b0);
        chk("after_abort_first", obs_first, 5);

        reset_test();
        run_play(16'h0001, 5'd2, 2'd0, 1, 1'b0, 1'b0);
        chk("after_reset_first", obs_first, 5);

        for (int r = 0; r < 20; r++) begin
            logic [15:0] sd;
            sd = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) sd = 16'h0;
            run_play(sd, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
